// File: rtl/pe_row_ws.sv
// pe_row_ws: weight-stationary systolic row of NPE multiply-accumulate cells.
//
// An X beat enters at cell 0 and moves one cell per clock. Each cell adds
// x * w (extended to AWIDTH) to its slice of psum_in and registers the result.
// Weights are double-buffered: a shadow bank is loaded serially (cell 0
// first) and then promoted to the active bank by w_swap, once no beat is in
// flight.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   mode_signed        1 = two's-complement operands for the beat being accepted
//   w_valid/w_data     weight word into the shadow bank, w_ready = can accept
//   w_swap/w_busy      promote shadow bank; w_busy while waiting for drain
//   x_valid/x_data     X beat into cell 0, x_ready = beat accepted
//   psum_in            NPE slices of AWIDTH, slice i feeds cell i (caller skews)
//   psum_out           registered partial sums, psum_valid per cell
//   x_out/x_out_valid  X leaving the last cell, one cycle after cell NPE-1
//   sat_flag           (PE_ROW_SAT_EN only) sticky per-cell saturation flag
//
// Build option: define PE_ROW_SAT_EN for saturating accumulation; otherwise
// sums wrap modulo 2^AWIDTH.
//
// Weight FSM states:
//   state      | meaning
//   FILL       | shadow bank accepting words, cnt = next cell to load
//   FULL       | shadow bank complete, waiting for w_swap
//   WAIT_DRAIN | swap requested, X input stalled until pipeline is empty

module pe_row_ws #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 32,
  parameter int NPE    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode_signed,
  input  logic                  w_valid,
  input  logic [DWIDTH-1:0]     w_data,
  output logic                  w_ready,
  input  logic                  w_swap,
  output logic                  w_busy,
  input  logic                  x_valid,
  input  logic [DWIDTH-1:0]     x_data,
  output logic                  x_ready,
  input  logic [NPE*AWIDTH-1:0] psum_in,
  output logic [NPE*AWIDTH-1:0] psum_out,
  output logic [NPE-1:0]        psum_valid,
  output logic [DWIDTH-1:0]     x_out,
  output logic                  x_out_valid
`ifdef PE_ROW_SAT_EN
  ,
  output logic [NPE-1:0]        sat_flag
`endif
);

  localparam int CW = $clog2(NPE);

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    FULL       = 2'd1,
    WAIT_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic shadow_we;
  logic swap;

  logic [NPE-1:0][DWIDTH-1:0] shadow_q;
  logic [NPE-1:0][DWIDTH-1:0] active_q;

  // Stage 0 is the beat being accepted this cycle; stages 1..NPE-1 are registers.
  logic                       x_acc;
  logic [NPE-1:1]             v_q;
  logic [NPE-1:1]             s_q;
  logic [NPE-1:1][DWIDTH-1:0] x_q;
  logic [NPE-1:0]             stg_v;
  logic [NPE-1:0]             stg_s;
  logic [NPE-1:0][DWIDTH-1:0] stg_x;
  logic                       in_flight;

  assign w_ready   = (state_q == FILL);
  assign w_busy    = (state_q == WAIT_DRAIN);
  assign x_ready   = (state_q != WAIT_DRAIN);
  assign x_acc     = x_valid && x_ready;
  assign stg_v     = {v_q, x_acc};
  assign stg_s     = {s_q, mode_signed};
  assign stg_x     = {x_q, x_data};
  assign in_flight = |stg_v;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_we = 1'b0;
    swap      = 1'b0;
    unique case (state_q)
      FILL: begin
        if (w_valid) begin
          shadow_we = 1'b1;
          if (cnt_q == CW'(NPE-1)) begin
            cnt_d   = '0;
            state_d = FULL;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      FULL: begin
        if (w_swap) begin
          if (!in_flight) begin
            swap    = 1'b1;
            state_d = FILL;
          end else begin
            state_d = WAIT_DRAIN;
          end
        end
      end
      WAIT_DRAIN: begin
        // x_acc is low here, so in_flight only reflects registered stages.
        if (!in_flight) begin
          swap    = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (shadow_we) shadow_q[cnt_q] <= w_data;
      if (swap)      active_q <= shadow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= '0;
      s_q         <= '0;
      x_q         <= '0;
      x_out       <= '0;
      x_out_valid <= 1'b0;
    end else begin
      v_q         <= stg_v[NPE-2:0];
      s_q         <= stg_s[NPE-2:0];
      x_q         <= stg_x[NPE-2:0];
      x_out_valid <= stg_v[NPE-1];
      if (stg_v[NPE-1]) x_out <= stg_x[NPE-1];
    end
  end

  for (genvar i = 0; i < NPE; i++) begin : g_cell
    logic [AWIDTH-1:0] pin;
    logic [AWIDTH-1:0] xe;
    logic [AWIDTH-1:0] we;
    logic [AWIDTH-1:0] addend;
    logic [AWIDTH-1:0] nxt;
    logic              ovf;
    logic [AWIDTH-1:0] acc_q;
    logic              vld_q;

    assign pin = psum_in[i*AWIDTH +: AWIDTH];
    // Extending operands first makes the low AWIDTH bits of the product equal
    // to the sign/zero-extended 2*DWIDTH product.
    assign xe = {{(AWIDTH-DWIDTH){stg_s[i] & stg_x[i][DWIDTH-1]}}, stg_x[i]};
    assign we = {{(AWIDTH-DWIDTH){stg_s[i] & active_q[i][DWIDTH-1]}}, active_q[i]};
    assign addend = xe * we;

`ifdef PE_ROW_SAT_EN
    logic [AWIDTH:0] sum_w;
    always_comb begin
      sum_w = {stg_s[i] & pin[AWIDTH-1], pin} + {stg_s[i] & addend[AWIDTH-1], addend};
      ovf   = stg_s[i] ? (sum_w[AWIDTH] ^ sum_w[AWIDTH-1]) : sum_w[AWIDTH];
      nxt   = sum_w[AWIDTH-1:0];
      if (ovf) begin
        if (!stg_s[i])          nxt = '1;
        else if (sum_w[AWIDTH]) nxt = {1'b1, {(AWIDTH-1){1'b0}}};
        else                    nxt = {1'b0, {(AWIDTH-1){1'b1}}};
      end
    end

    logic sat_q;
    always_ff @(posedge clk) begin
      if (rst)                  sat_q <= 1'b0;
      else if (stg_v[i] && ovf) sat_q <= 1'b1;
    end
    assign sat_flag[i] = sat_q;
`else
    assign nxt = pin + addend;
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q <= '0;
        vld_q <= 1'b0;
      end else begin
        vld_q <= stg_v[i];
        if (stg_v[i]) acc_q <= nxt;
      end
    end

    assign psum_out[i*AWIDTH +: AWIDTH] = acc_q;
    assign psum_valid[i]                = vld_q;
  end

endmodule

// File: tb/tb_pe_row_ws.sv
module tb_pe_row_ws;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int N  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             mode_signed = 1'b0;
  logic             w_valid = 1'b0;
  logic [DW-1:0]    w_data = '0;
  logic             w_ready;
  logic             w_swap = 1'b0;
  logic             w_busy;
  logic             x_valid = 1'b0;
  logic [DW-1:0]    x_data = '0;
  logic             x_ready;
  logic [N*AW-1:0]  psum_in = '0;
  logic [N*AW-1:0]  psum_out;
  logic [N-1:0]     psum_valid;
  logic [DW-1:0]    x_out;
  logic             x_out_valid;
`ifdef PE_ROW_SAT_EN
  logic [N-1:0]     sat_flag;
`endif

  pe_row_ws #(.DWIDTH(DW), .AWIDTH(AW), .NPE(N)) dut (
    .clk(clk), .rst(rst), .mode_signed(mode_signed),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .w_swap(w_swap), .w_busy(w_busy),
    .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
    .psum_in(psum_in), .psum_out(psum_out), .psum_valid(psum_valid),
    .x_out(x_out), .x_out_valid(x_out_valid)
`ifdef PE_ROW_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int                     acc;
    logic [DW-1:0]          x;
    bit                     sg;
    logic [N-1:0][DW-1:0]   w;
  } beat_t;

  beat_t                beats[$];
  logic [N-1:0][DW-1:0] m_active, m_shadow;
  int                   m_cnt;
  bit                   m_full, m_pend;
  logic [AW-1:0]        e_ps[N];
  bit                   e_pv[N];
  bit                   e_sat[N];
  logic [DW-1:0]        e_xo;
  bit                   e_xov, e_wready, e_xready, e_busy;
  bit                   started = 1'b0;
  int                   k = 0;

  function automatic void cell_calc(input logic [AW-1:0] pin, input logic [DW-1:0] x,
                                    input logic [DW-1:0] w, input bit sg,
                                    output logic [AW-1:0] res, output bit sat);
    longint s;
    if (sg) s = longint'($signed(pin)) + longint'($signed(x)) * longint'($signed(w));
    else    s = longint'(pin) + longint'(x) * longint'(w);
    sat = 1'b0;
`ifdef PE_ROW_SAT_EN
    begin
      longint lo, hi;
      if (sg) begin lo = -(64'sd1 <<< (AW-1)); hi = (64'sd1 <<< (AW-1)) - 1; end
      else    begin lo = 0;                    hi = (64'sd1 <<< AW) - 1;     end
      if (s > hi)      begin s = hi; sat = 1'b1; end
      else if (s < lo) begin s = lo; sat = 1'b1; end
    end
`endif
    res = s[AW-1:0];
  endfunction

  always @(posedge clk) begin : model
    beat_t         b;
    logic [AW-1:0] r;
    bit            s, busy_pipe;
    k++;
    if (rst) begin
      beats.delete();
      m_active = '0; m_shadow = '0; m_cnt = 0; m_full = 0; m_pend = 0;
      for (int i = 0; i < N; i++) begin e_ps[i] = '0; e_pv[i] = 0; e_sat[i] = 0; end
      e_xo = '0; e_xov = 0;
      started = 1'b1;
    end else if (started) begin
      while (beats.size() > 0 && beats[0].acc <= k - N) void'(beats.pop_front());
      if (x_valid && !m_pend) begin
        b.acc = k; b.x = x_data; b.sg = mode_signed; b.w = m_active;
        beats.push_back(b);
      end
      for (int i = 0; i < N; i++) e_pv[i] = 0;
      e_xov = 0;
      foreach (beats[j]) begin
        for (int i = 0; i < N; i++) begin
          if (beats[j].acc == k - i) begin
            cell_calc(psum_in[i*AW +: AW], beats[j].x, beats[j].w[i], beats[j].sg, r, s);
            e_ps[i] = r;
            e_pv[i] = 1;
            if (s) e_sat[i] = 1;
          end
        end
        if (beats[j].acc == k - (N - 1)) begin
          e_xo = beats[j].x;
          e_xov = 1;
        end
      end
      busy_pipe = (beats.size() > 0);
      if (!m_full) begin
        if (w_valid) begin
          m_shadow[m_cnt] = w_data;
          m_cnt++;
          if (m_cnt == N) begin m_cnt = 0; m_full = 1; end
        end
      end else if (!m_pend) begin
        if (w_swap) begin
          if (!busy_pipe) begin m_active = m_shadow; m_full = 0; end
          else m_pend = 1;
        end
      end else if (!busy_pipe) begin
        m_active = m_shadow; m_full = 0; m_pend = 0;
      end
    end
    e_wready = !m_full;
    e_xready = !m_pend;
    e_busy   = m_pend;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("psum_valid[%0d]", i), psum_valid[i], e_pv[i]);
        chk($sformatf("psum_out[%0d]", i), psum_out[i*AW +: AW], e_ps[i]);
`ifdef PE_ROW_SAT_EN
        chk($sformatf("sat_flag[%0d]", i), sat_flag[i], e_sat[i]);
`endif
      end
      chk("x_out_valid", x_out_valid, e_xov);
      if (e_xov) chk("x_out", x_out, e_xo);
      chk("w_ready", w_ready, e_wready);
      chk("x_ready", x_ready, e_xready);
      chk("w_busy", w_busy, e_busy);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_bank(input logic [N-1:0][DW-1:0] ws);
    for (int i = 0; i < N; i++) begin
      w_valid = 1'b1; w_data = ws[i];
      tick(1);
    end
    w_valid = 1'b0;
  endtask

  task automatic do_swap();
    w_swap = 1'b1; tick(1); w_swap = 1'b0;
  endtask

  logic [AW-1:0] exp_v;
  int            n;

  initial begin
    tick(2);
    rst = 1'b0;
    chk("rst_psum_out", psum_out, 0);
    chk("rst_psum_valid", psum_valid, 0);
    chk("rst_x_out_valid", x_out_valid, 0);
    chk("rst_w_busy", w_busy, 0);
    chk("rst_w_ready", w_ready, 1);
    chk("rst_x_ready", x_ready, 1);

    // basic row: weights 1..4, x = 5
    load_bank({8'd4, 8'd3, 8'd2, 8'd1});
    chk("full_w_ready", w_ready, 0);
    do_swap();
    chk("swap_w_ready", w_ready, 1);
    x_valid = 1'b1; x_data = 8'd5; mode_signed = 1'b0;
    tick(1);
    x_valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (j > 0) tick(1);
      chk($sformatf("basic_psum[%0d]", j), psum_out[j*AW +: AW], 5 * (j + 1));
      chk($sformatf("basic_valid[%0d]", j), psum_valid[j], 1);
    end
    chk("basic_x_out", x_out, 5);
    chk("basic_x_out_valid", x_out_valid, 1);

    // signed vs unsigned: w0 = 0xFF, x = 3, psum_in[0] = 10
    load_bank({8'd0, 8'd0, 8'd0, 8'hFF});
    do_swap();
    psum_in[0 +: AW] = 16'd10;
    x_valid = 1'b1; x_data = 8'd3; mode_signed = 1'b1;
    tick(1);
    chk("signed_psum0", psum_out[0 +: AW], 7);
    mode_signed = 1'b0;
    tick(1);
    chk("unsigned_psum0", psum_out[0 +: AW], 775);
    x_valid = 1'b0;
    tick(N);
    psum_in = '0;

    // swap while beats are in flight
    load_bank({DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)});
    x_valid = 1'b1; mode_signed = 1'b1;
    x_data = DW'($urandom); tick(1);
    x_data = DW'($urandom); tick(1);
    x_data = DW'($urandom); w_swap = 1'b1; tick(1);
    w_swap = 1'b0;
    chk("drain_w_busy", w_busy, 1);
    chk("drain_x_ready", x_ready, 0);
    x_data = DW'($urandom);
    n = 0;
    while (w_busy && n < 20) begin tick(1); n++; end
    chk("drain_len", n, 4);
    chk("drain_end_pv3", psum_valid[N-1], 0);
    chk("drain_end_x_ready", x_ready, 1);
    tick(1);
    x_valid = 1'b0;
    tick(N + 1);

    // partial bank then swap: ignored
    for (int i = 0; i < 3; i++) begin w_valid = 1'b1; w_data = 8'd9; tick(1); end
    w_valid = 1'b0;
    do_swap();
    chk("partial_w_ready", w_ready, 1);
    chk("partial_w_busy", w_busy, 0);
    x_valid = 1'b1; x_data = 8'd1; mode_signed = 1'b0;
    tick(1);
    x_valid = 1'b0;
    tick(N + 1);

    // reset mid-load, then a clean load must land on cells 0..3
    for (int i = 0; i < 2; i++) begin w_valid = 1'b1; w_data = 8'd7; tick(1); end
    w_valid = 1'b0;
    rst = 1'b1; tick(1); rst = 1'b0;
    load_bank({8'd5, 8'd4, 8'd3, 8'd2});
    do_swap();
    x_valid = 1'b1; x_data = 8'd1; mode_signed = 1'b0;
    tick(1);
    x_valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (j > 0) tick(1);
      chk($sformatf("reload_psum[%0d]", j), psum_out[j*AW +: AW], j + 2);
    end

    // wrap vs saturate, unsigned: 0xFFF0 + 0x20
`ifdef PE_ROW_SAT_EN
    exp_v = 16'hFFFF;
`else
    exp_v = 16'h0010;
`endif
    load_bank({8'd4, 8'd4, 8'd4, 8'd4});
    do_swap();
    psum_in = {N{16'hFFF0}};
    x_valid = 1'b1; x_data = 8'd8; mode_signed = 1'b0;
    tick(1);
    x_valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (j > 0) tick(1);
      chk($sformatf("ovf_psum[%0d]", j), psum_out[j*AW +: AW], exp_v);
`ifdef PE_ROW_SAT_EN
      chk($sformatf("ovf_sat_flag[%0d]", j), sat_flag[j], 1);
`endif
    end
    psum_in = '0;

    // idle: outputs hold, valids low
    tick(5);
    for (int j = 0; j < N; j++)
      chk($sformatf("idle_hold[%0d]", j), psum_out[j*AW +: AW], exp_v);
    chk("idle_psum_valid", psum_valid, 0);
    chk("idle_x_out_valid", x_out_valid, 0);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 149) == 0);
      x_valid     = $urandom_range(0, 2) != 0;
      x_data      = DW'($urandom);
      mode_signed = $urandom_range(0, 1) == 1;
      w_valid     = $urandom_range(0, 1) == 1;
      w_data      = DW'($urandom);
      w_swap      = $urandom_range(0, 3) == 0;
      psum_in     = {$urandom(), $urandom()};
      tick(1);
    end
    rst = 1'b0; x_valid = 1'b0; w_valid = 1'b0; w_swap = 1'b0;
    tick(N + 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
